// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: PRBS receiver for the 8-bit LFSR pattern generator
// (feedback d[7]^d[3]^d[2]^d[1], shift-left, feedback into bit 0).
// It synchronises to the incoming word stream, then flags and counts every
// word that deviates from the predicted sequence while locked.
//
// state  | meaning
// -------+-------------------------------------------------------------
// HUNT   | waiting for a nonzero word to seed the predictor
// VERIFY | seeded; counting consecutive correct predictions toward lock
// LOCKED | synchronised; predictor free-runs, mismatches are errors
module lfsr_seq_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    state_t           state_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] err_count_q;
    logic [7:0]       pred_q;
    logic [3:0]       match_cnt_q;
    logic [3:0]       miss_cnt_q;

    // Next word produced by the generator after x.
    function automatic logic [7:0] nxt(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[3] ^ x[2] ^ x[1]};
    endfunction

    // Sync/lock state machine, predictor, error pulse and saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            pred_q      <= 8'h00;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
        end else begin
            err_pulse_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        // 0x00 is the LFSR lock-up value and can never seed.
                        if (in_data != 8'h00) begin
                            pred_q      <= nxt(in_data);
                            match_cnt_q <= 4'd0;
                            state_q     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (in_data == pred_q) begin
                            pred_q      <= nxt(in_data);
                            match_cnt_q <= match_cnt_q + 4'd1;
                            if (match_cnt_q + 4'd1 == LOCK_C) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                miss_cnt_q <= 4'd0;
                            end
                        end else if (in_data != 8'h00) begin
                            pred_q      <= nxt(in_data);
                            match_cnt_q <= 4'd0;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Free-running predictor: a single corrupted word
                        // costs exactly one error instead of a resync burst.
                        pred_q <= nxt(pred_q);
                        if (in_data == pred_q) begin
                            miss_cnt_q <= 4'd0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (err_count_q != '1) begin
                                err_count_q <= err_count_q + CNT_W'(1);
                            end
                            miss_cnt_q <= miss_cnt_q + 4'd1;
                            if (miss_cnt_q + 4'd1 == LOSS_C) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            // Clear wins over a same-edge increment.
            if (clr_cnt) begin
                err_count_q <= '0;
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker with a scoreboard queue of expected
// post-edge output snapshots.
module tb_lfsr_seq_checker;

    localparam int CNT_W = 4;
    localparam logic [1:0] S_HUNT = 2'd0, S_VERIFY = 2'd1, S_LOCKED = 2'd2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             clr_cnt = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state;

    typedef struct packed {
        logic [1:0]       st;
        logic             lk;
        logic             ep;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] w;
    logic [CNT_W-1:0] exp_cnt;

    lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nxt(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[3] ^ x[2] ^ x[1]};
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        n_tests++;
        assert (state === e.st) else begin
            n_fail++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, state, e.st);
        end
        n_tests++;
        assert (locked === e.lk) else begin
            n_fail++;
            $error("FAIL %s locked obs=%0b exp=%0b", tag, locked, e.lk);
        end
        n_tests++;
        assert (err_pulse === e.ep) else begin
            n_fail++;
            $error("FAIL %s err_pulse obs=%0b exp=%0b", tag, err_pulse, e.ep);
        end
        n_tests++;
        assert (err_count === e.cnt) else begin
            n_fail++;
            $error("FAIL %s err_count obs=%0d exp=%0d", tag, err_count, e.cnt);
        end
    endtask

    // Drive one cycle, push the expected post-edge snapshot, then pop and
    // compare it just after the edge.
    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic clr, input logic [1:0] st, input logic lk,
                        input logic ep, input logic [CNT_W-1:0] cnt);
        exp_t e;
        in_valid = v;
        in_data  = d;
        clr_cnt  = clr;
        sb_q.push_back('{st: st, lk: lk, ep: ep, cnt: cnt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_outputs(tag, e);
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check_outputs("reset", '{st: S_HUNT, lk: 1'b0, ep: 1'b0, cnt: '0});
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // Lock acquisition: seed + 4 correct words
        w = 8'hBD;
        step("seed", 1'b1, w, 1'b0, S_VERIFY, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            w = nxt(w);
            step("verify", 1'b1, w, 1'b0, S_VERIFY, 1'b0, 1'b0, 4'd0);
        end
        w = nxt(w);
        step("lock", 1'b1, w, 1'b0, S_LOCKED, 1'b1, 1'b0, 4'd0);
        step("idle_locked", 1'b0, 8'hA5, 1'b0, S_LOCKED, 1'b1, 1'b0, 4'd0);

        // Single-word corruption
        w = nxt(w);
        step("corrupt", 1'b1, w ^ 8'h01, 1'b0, S_LOCKED, 1'b1, 1'b1, 4'd1);
        for (int i = 0; i < 3; i++) begin
            w = nxt(w);
            step("post_corrupt", 1'b1, w, 1'b0, S_LOCKED, 1'b1, 1'b0, 4'd1);
        end

        // Loss of lock: 3 consecutive wrong words (first one is 0x00)
        w = nxt(w);
        step("loss1_zero", 1'b1, 8'h00, 1'b0, S_LOCKED, 1'b1, 1'b1, 4'd2);
        w = nxt(w);
        step("loss2", 1'b1, ~w, 1'b0, S_LOCKED, 1'b1, 1'b1, 4'd3);
        w = nxt(w);
        step("loss3", 1'b1, ~w, 1'b0, S_HUNT, 1'b0, 1'b1, 4'd4);
        step("hunt_zero", 1'b1, 8'h00, 1'b0, S_HUNT, 1'b0, 1'b0, 4'd4);
        step("hunt_seed", 1'b1, 8'hBD, 1'b0, S_VERIFY, 1'b0, 1'b0, 4'd4);

        // VERIFY reseed
        step("reseed_m1", 1'b1, 8'h7B, 1'b0, S_VERIFY, 1'b0, 1'b0, 4'd4);
        w = 8'h55;
        step("reseed", 1'b1, w, 1'b0, S_VERIFY, 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 3; i++) begin
            w = nxt(w);
            step("reseed_chain", 1'b1, w, 1'b0, S_VERIFY, 1'b0, 1'b0, 4'd4);
        end
        w = nxt(w);
        step("relock", 1'b1, w, 1'b0, S_LOCKED, 1'b1, 1'b0, 4'd4);

        // Saturation: 20 mismatches in pairs, each pair followed by a good word
        exp_cnt = 4'd4;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 2; j++) begin
                w = nxt(w);
                if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
                step("sat_err", 1'b1, w ^ 8'h80, 1'b0, S_LOCKED, 1'b1, 1'b1, exp_cnt);
            end
            w = nxt(w);
            step("sat_good", 1'b1, w, 1'b0, S_LOCKED, 1'b1, 1'b0, exp_cnt);
        end
        step("sat_hold", 1'b0, 8'h00, 1'b0, S_LOCKED, 1'b1, 1'b0, 4'hF);

        // Clear on the same edge as a mismatch: clear wins, pulse still fires
        w = nxt(w);
        step("clr_vs_err", 1'b1, ~w, 1'b1, S_LOCKED, 1'b1, 1'b1, 4'd0);
        w = nxt(w);
        step("clr_after", 1'b1, w, 1'b0, S_LOCKED, 1'b1, 1'b0, 4'd0);
        w = nxt(w);
        step("err_again", 1'b1, w ^ 8'h10, 1'b0, S_LOCKED, 1'b1, 1'b1, 4'd1);
        step("clr_idle", 1'b0, 8'h00, 1'b1, S_LOCKED, 1'b1, 1'b0, 4'd0);

        // Asynchronous reset while locked, checked before the next edge
        w = nxt(w);
        step("pre_rst_err", 1'b1, ~w, 1'b0, S_LOCKED, 1'b1, 1'b1, 4'd1);
        rst = 1'b1;
        #1;
        check_outputs("async_rst", '{st: S_HUNT, lk: 1'b0, ep: 1'b0, cnt: '0});
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // VERIFY with a 0x00 mismatch returns to HUNT
        step("v_seed", 1'b1, 8'h3C, 1'b0, S_VERIFY, 1'b0, 1'b0, 4'd0);
        step("v_zero", 1'b1, 8'h00, 1'b0, S_HUNT, 1'b0, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout sim_time=%0t limit=50000", $time);
        $fatal(1, "timeout");
    end

endmodule
